// File: rtl/param_fifo.sv
// Parametrised synchronous FIFO for the SSP data path: occupancy count, almost-full/empty flags, sticky error flags.
// Define PARAM_FIFO_FWFT_EN for a first-word fall-through read port; the default build has a registered read.
module param_fifo #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1
) (
    input  logic                     pclk,
    input  logic                     clear,
    input  logic                     en,
    input  logic                     wrReq,
    input  logic [WIDTH-1:0]         wordIn,
    input  logic                     rdReq,
    output logic [WIDTH-1:0]         wordOut,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     almostFull,
    output logic                     almostEmpty,
    output logic                     overflow,
    output logic                     underflow,
    input  logic                     intrClr,
    output logic                     intr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wp_q, wp_d;
    logic [AW-1:0]    rp_q, rp_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             wr_acc, rd_acc;

    assign count       = count_q;
    assign full        = (count_q == CW'(DEPTH));
    assign empty       = (count_q == '0);
    assign almostFull  = (count_q >= CW'(AF_LEVEL));
    assign almostEmpty = (count_q <= CW'(AE_LEVEL));
    assign overflow    = ovf_q;
    assign underflow   = unf_q;
    assign intr        = ovf_q | unf_q;

    // NOTE: every always_comb target gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        rd_acc  = en && rdReq && !empty;
        wr_acc  = en && wrReq && (!full || rd_acc);
        mem_d   = mem_q;
        wp_d    = wp_q;
        rp_d    = rp_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        count_d = count_q + CW'(wr_acc) - CW'(rd_acc);

        if (wr_acc) begin
            mem_d[wp_q] = wordIn;
            wp_d        = wp_q + AW'(1);
        end
        if (rd_acc) begin
            rp_d = rp_q + AW'(1);
        end

        // A new error in the same cycle as intrClr must survive, so the set comes last.
        if (en && intrClr) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
        if (en && wrReq && !wr_acc) ovf_d = 1'b1;
        if (en && rdReq && !rd_acc) unf_d = 1'b1;
    end

    // NOTE: sequential state is updated only with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge pclk) begin
        if (clear) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // NOTE: the storage array has no reset; its contents are don't-care after clear and the pointers gate every read.
    always_ff @(posedge pclk) begin
        mem_q <= mem_d;
    end

`ifdef PARAM_FIFO_FWFT_EN
    assign wordOut = empty ? '0 : mem_q[rp_q];
`else
    logic [WIDTH-1:0] rdata_q, rdata_d;

    always_comb begin
        rdata_d = rd_acc ? mem_q[rp_q] : rdata_q;
    end

    always_ff @(posedge pclk) begin
        if (clear) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign wordOut = rdata_q;
`endif

endmodule

// File: tb/tb_param_fifo.sv
// Self-checking bench for param_fifo (WIDTH=8, DEPTH=4): a queue scoreboard predicts wordOut, count and error flags.
module tb_param_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             pclk = 1'b0;
    logic             clear = 1'b0;
    logic             en = 1'b1;
    logic             wrReq = 1'b0;
    logic [WIDTH-1:0] wordIn = '0;
    logic             rdReq = 1'b0;
    logic [WIDTH-1:0] wordOut;
    logic [2:0]       count;
    logic             full, empty, almostFull, almostEmpty;
    logic             overflow, underflow;
    logic             intrClr = 1'b0;
    logic             intr;

    param_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .pclk       (pclk),
        .clear      (clear),
        .en         (en),
        .wrReq      (wrReq),
        .wordIn     (wordIn),
        .rdReq      (rdReq),
        .wordOut    (wordOut),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .almostFull (almostFull),
        .almostEmpty(almostEmpty),
        .overflow   (overflow),
        .underflow  (underflow),
        .intrClr    (intrClr),
        .intr       (intr)
    );

    always #5 pclk = ~pclk;

    int               total = 0;
    int               bad = 0;
    logic [WIDTH-1:0] sb[$];
    logic [WIDTH-1:0] exp_word = '0;
    bit               exp_ovf = 1'b0;
    bit               exp_unf = 1'b0;

    // Drive one cycle of stimulus, update the scoreboard with the expected effect, then sample #1 after the edge.
    task automatic step(input bit w, input logic [WIDTH-1:0] d, input bit r,
                        input bit e, input bit clr, input bit iclr);
        bit rd_ok, wr_ok;
        clear = clr; en = e; wrReq = w; wordIn = d; rdReq = r; intrClr = iclr;
        if (clr) begin
            sb.delete();
            exp_ovf  = 1'b0;
            exp_unf  = 1'b0;
            exp_word = '0;
        end else if (e) begin
            rd_ok = r && (sb.size() != 0);
            wr_ok = w && ((sb.size() != DEPTH) || rd_ok);
            if (iclr) begin
                exp_ovf = 1'b0;
                exp_unf = 1'b0;
            end
            if (w && !wr_ok) exp_ovf = 1'b1;
            if (r && !rd_ok) exp_unf = 1'b1;
            if (rd_ok) exp_word = sb.pop_front();
            if (wr_ok) sb.push_back(d);
        end
`ifdef PARAM_FIFO_FWFT_EN
        exp_word = (sb.size() != 0) ? sb[0] : '0;
`endif
        @(posedge pclk);
        #1;
        clear = 1'b0; en = 1'b1; wrReq = 1'b0; rdReq = 1'b0; intrClr = 1'b0;
    endtask

    task automatic wr(input logic [WIDTH-1:0] d);
        step(1'b1, d, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic rd();
        step(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        step(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
        total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        total++; if ({empty, full, almostEmpty, almostFull} !== 4'b1010) begin
            bad++; $display("FAIL reset_flags got e/f/ae/af=%b exp=1010", {empty, full, almostEmpty, almostFull});
        end
        total++; if (intr !== 1'b0) begin bad++; $display("FAIL reset_intr got=%b exp=0", intr); end
        total++; if (wordOut !== 8'h00) begin bad++; $display("FAIL reset_word got=%h exp=00", wordOut); end

        rd();
        total++; if ({underflow, intr} !== 2'b11) begin bad++; $display("FAIL empty_read_err got unf/intr=%b exp=11", {underflow, intr}); end
        total++; if (count !== 3'd0 || wordOut !== 8'h00) begin
            bad++; $display("FAIL empty_read_state got count=%0d word=%h exp count=0 word=00", count, wordOut);
        end

        step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
        total++; if ({underflow, intr} !== 2'b00) begin bad++; $display("FAIL intr_clear got unf/intr=%b exp=00", {underflow, intr}); end
    endtask

    task automatic test_fill_overflow();
        logic [WIDTH-1:0] word_set [4] = '{"c", "a", "t", "s"};
        for (int i = 0; i < 4; i++) begin
            wr(word_set[i]);
            total++; if (count !== 3'(i + 1)) begin bad++; $display("FAIL fill_count%0d got=%0d exp=%0d", i, count, i + 1); end
            total++; if (almostFull !== (i + 1 >= 3) || full !== (i + 1 == 4)) begin
                bad++; $display("FAIL fill_flags%0d got af/f=%b%b exp=%b%b", i, almostFull, full, (i + 1 >= 3), (i + 1 == 4));
            end
        end
        wr("x");
        total++; if (overflow !== 1'b1 || count !== 3'd4) begin
            bad++; $display("FAIL overflow got ovf=%b count=%0d exp ovf=1 count=4", overflow, count);
        end
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            rd();
            total++; if (wordOut !== exp_word) begin bad++; $display("FAIL drain_word%0d got=%h exp=%h", i, wordOut, exp_word); end
        end
        total++; if (empty !== 1'b1 || count !== 3'd0) begin bad++; $display("FAIL drain_empty got empty=%b count=%0d exp 1/0", empty, count); end
    endtask

    task automatic test_wrap();
        wr("b"); wr("i");
        rd();
        total++; if (wordOut !== exp_word) begin bad++; $display("FAIL wrap_pre0 got=%h exp=%h", wordOut, exp_word); end
        rd();
        total++; if (wordOut !== exp_word) begin bad++; $display("FAIL wrap_pre1 got=%h exp=%h", wordOut, exp_word); end
        wr("r"); wr("d"); wr("s"); wr("!");
        total++; if (full !== 1'b1 || overflow !== 1'b0) begin bad++; $display("FAIL wrap_full got full=%b ovf=%b exp 1/0", full, overflow); end
        for (int i = 0; i < 4; i++) begin
            rd();
            total++; if (wordOut !== exp_word) begin bad++; $display("FAIL wrap_word%0d got=%h exp=%h", i, wordOut, exp_word); end
        end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL wrap_empty got=%b exp=1", empty); end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 4; i++) wr(8'h11 * (i + 1));
        step(1'b1, 8'h55, 1'b1, 1'b1, 1'b0, 1'b0);
        total++; if (count !== 3'd4 || overflow !== 1'b0) begin
            bad++; $display("FAIL rw_full got count=%0d ovf=%b exp count=4 ovf=0", count, overflow);
        end
        total++; if (wordOut !== exp_word) begin bad++; $display("FAIL rw_full_word got=%h exp=%h", wordOut, exp_word); end
        for (int i = 0; i < 4; i++) begin
            rd();
            total++; if (wordOut !== exp_word) begin bad++; $display("FAIL rw_drain%0d got=%h exp=%h", i, wordOut, exp_word); end
        end
        step(1'b1, 8'h66, 1'b1, 1'b1, 1'b0, 1'b0);
        total++; if (underflow !== 1'b1 || count !== 3'd1 || empty !== 1'b0) begin
            bad++; $display("FAIL rw_empty got unf=%b count=%0d empty=%b exp 1/1/0", underflow, count, empty);
        end
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
        rd();
        total++; if (wordOut !== exp_word || underflow !== exp_unf) begin
            bad++; $display("FAIL rw_empty_word got=%h unf=%b exp=%h unf=%b", wordOut, underflow, exp_word, exp_unf);
        end
    endtask

    task automatic test_enable_clear();
        wr(8'ha0); wr(8'ha1); wr(8'ha2);
        rd();
        wr(8'ha3);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 8'hee, 1'b1, 1'b0, 1'b0, 1'b0);
            total++; if (count !== 3'd3 || wordOut !== exp_word || overflow !== 1'b0 || underflow !== 1'b0) begin
                bad++; $display("FAIL en_hold%0d got count=%0d word=%h ovf=%b unf=%b exp count=3 word=%h ovf=0 unf=0",
                                i, count, wordOut, overflow, underflow, exp_word);
            end
        end
        rd();
        total++; if (wordOut !== exp_word) begin bad++; $display("FAIL en_resume got=%h exp=%h", wordOut, exp_word); end
        wr(8'ha4);
        step(1'b1, 8'hff, 1'b0, 1'b1, 1'b1, 1'b0);
        total++; if (count !== 3'd0 || empty !== 1'b1 || wordOut !== 8'h00) begin
            bad++; $display("FAIL mid_clear got count=%0d empty=%b word=%h exp 0/1/00", count, empty, wordOut);
        end
    endtask

`ifdef PARAM_FIFO_FWFT_EN
    task automatic test_fwft();
        wr("c");
        total++; if (wordOut !== 8'h63) begin bad++; $display("FAIL fwft_show got=%h exp=63", wordOut); end
        rd();
        total++; if (wordOut !== 8'h00 || empty !== 1'b1) begin
            bad++; $display("FAIL fwft_pop got word=%h empty=%b exp 00/1", wordOut, empty);
        end
    endtask
`endif

    initial begin
        @(posedge pclk);
        #1;
        test_reset();
        test_fill_overflow();
        test_wrap();
        test_simultaneous();
        test_enable_clear();
`ifdef PARAM_FIFO_FWFT_EN
        test_fwft();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/param_fifo.md
Name: param_fifo

Overview:
- Parametrised synchronous FIFO; next-generation replacement for the fixed 8-bit single-rw buffer in the SSP data path.
- Separate read and write requests, so one read and one write can complete in the same cycle.
- Generalises width and depth; adds occupancy count, programmable almost-full/almost-empty flags, and sticky overflow/underflow error flags with an interrupt.
- Sits between the SSP shift logic and the bus side.

Parameters:
- WIDTH, 8: data word width in bits (≥1).
- DEPTH, 4: number of entries; power of two, ≥2.
- AF_LEVEL, DEPTH-1: almostFull asserts when count ≥ AF_LEVEL.
- AE_LEVEL, 1: almostEmpty asserts when count ≤ AE_LEVEL.

Ports:
- pclk  in  1  clock; all state updates on the rising edge.
- clear  in  1  synchronous reset, active-high.
- en  in  1  block enable; when low, wrReq/rdReq are ignored and all state holds.
- wrReq  in  1  write request.
- wordIn  in  WIDTH  write data.
- rdReq  in  1  read request.
- wordOut  out  WIDTH  read data.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almostFull  out  1  count ≥ AF_LEVEL.
- almostEmpty  out  1  count ≤ AE_LEVEL.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.
- intrClr  in  1  clears overflow and underflow (synchronous, single cycle).
- intr  out  1  overflow | underflow.

Behaviour:
- Storage:
  - DEPTH×WIDTH register array.
  - Write pointer wp and read pointer rp, each $clog2(DEPTH) bits, wrapping naturally from DEPTH-1 to 0.
  - count register, $clog2(DEPTH)+1 bits.
  - All flags (full, empty, almostFull, almostEmpty) are combinational from count.
- Reset (clear=1, highest priority, regardless of en): wp=rp=0, count=0, wordOut=0, overflow=underflow=0. Outputs after reset: empty=1, full=0, almostEmpty=1, almostFull=0 (for DEPTH≥2 with default levels), intr=0. Array contents are don't-care.
- Accept rules, with en=1:
  - wrAcc = wrReq & (!full | rdAcc).
  - rdAcc = rdReq & !empty.
  - Read on empty is rejected even if a write occurs the same cycle; the write is accepted.
  - Write on full is accepted only if a read is accepted the same cycle.
- Write: mem[wp] ← wordIn; wp ← wp+1.
- Read: wordOut ← mem[rp] (registered, valid the cycle after rdReq accepted); rp ← rp+1. wordOut holds its value when no read is accepted.
- Count update:
  - count ← count + wrAcc − rdAcc.
  - Simultaneous accepted read and write leaves count unchanged.
- Errors:
  - wrReq & !wrAcc sets overflow.
  - rdReq & !rdAcc sets underflow.
  - Both flags are sticky until clear or intrClr.
  - If intrClr and a new error coincide in the same cycle, the set wins.
  - Requests with en=0 never set the error flags.
- Rejected operations never change pointers, count, memory or wordOut.
- No state machine beyond the pointer/count registers. Latency: write-to-readable 1 cycle (empty deasserts the cycle after the write).

Optional Feature:
- Macro PARAM_FIFO_FWFT_EN.
- Defined (first-word fall-through):
  - wordOut is combinational mem[rp] whenever !empty; it is 0 when empty.
  - rdReq acknowledges and pops the currently shown word, so read latency is 0.
  - Accept rules and flags are unchanged.
- Undefined: registered read with 1-cycle latency, as described above.

Test Plan:
- Reset, then rdReq=1 for 1 cycle while empty → wordOut=0, count=0, underflow=1, intr=1. Then intrClr=1 for 1 cycle → intr=0.
- WIDTH=8, DEPTH=4: write 'c','a','t','s' → count=4, full=1, almostFull=1 from count 3. A 5th write 'x' → overflow=1, count stays 4, memory unchanged. Then 4 reads → wordOut sequence 'c','a','t','s' (each 1 cycle after its rdReq), empty=1.
- Wrap-around: write 'b','i', read 2, then write 'r','d','s','!' → full=1. Reads return 'r','d','s','!'; pointers wrap with no corruption.
- Simultaneous read/write while full → count stays 4, overflow stays 0, the output is the oldest word. Simultaneous read/write while empty → write accepted, underflow=1, count=1.
- en=0 with wrReq=rdReq=1 for 5 cycles → no change to count, pointers, wordOut or error flags. Assert clear mid-burst at count=3 → next cycle count=0, empty=1, wordOut=0.
- With PARAM_FIFO_FWFT_EN defined: write 'c' → wordOut='c' the next cycle without rdReq. Pop with rdReq → wordOut=0 and empty=1 the following cycle.
